// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble and forwarding control for the 5-stage MIPS core.
// It tracks the destination register and remaining Tnew of the instructions in
// E, M and W. From that state and the D-stage timing tuple it produces the
// stall, the forwarding selects and the mult/div HI/LO interlock.
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       need_rs,
    input  logic       need_rt,
    input  logic [2:0] Tuse_rs,
    input  logic [2:0] Tuse_rt,
    input  logic [2:0] Tnew,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [4:0] d_dst,
    input  logic       d_md_use,
    input  logic       d_md_start,
    input  logic       d_md_div,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       fwd_m_rt,
    output logic       md_busy
);

    // E-stage tracking entry
    logic [4:0] e_dst;
    logic [2:0] e_tnew;
    logic [4:0] e_rs;
    logic [4:0] e_rt;
    logic       e_md_start;
    logic       e_md_div;

    // M-stage tracking entry
    logic [4:0] m_dst;
    logic [2:0] m_tnew;
    logic [4:0] m_rt;

    // W-stage tracking entry
    logic [4:0] w_dst;
    logic [2:0] w_tnew;

    // mult/div busy count
    logic [3:0] busy;

    logic stall_rs;
    logic stall_rt;
    logic stall_md;

    // Tnew counts down as an instruction moves on, and never wraps below 0.
    function automatic logic [2:0] dec_sat(input logic [2:0] t);
        return (t == 3'd0) ? 3'd0 : t - 3'd1;
    endfunction

    // Forwarding source for a register: the E/M result wins over the M/W
    // result. Register 0 is hard-wired, so it is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] r,
        input logic [4:0] md,
        input logic [2:0] mt,
        input logic [4:0] wd,
        input logic [2:0] wt
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (r != 5'd0) begin
            if (md == r && mt == 3'd0) begin
                sel = 2'd1;
            end else if (wd == r && wt == 3'd0) begin
                sel = 2'd2;
            end
        end
        return sel;
    endfunction

    // Advance the tracking pipeline; a stall drops a bubble into E.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_dst      <= 5'd0;
            e_tnew     <= 3'd0;
            e_rs       <= 5'd0;
            e_rt       <= 5'd0;
            e_md_start <= 1'b0;
            e_md_div   <= 1'b0;
            m_dst      <= 5'd0;
            m_tnew     <= 3'd0;
            m_rt       <= 5'd0;
            w_dst      <= 5'd0;
            w_tnew     <= 3'd0;
        end else begin
            if (stall) begin
                e_dst      <= 5'd0;
                e_tnew     <= 3'd0;
                e_rs       <= 5'd0;
                e_rt       <= 5'd0;
                e_md_start <= 1'b0;
                e_md_div   <= 1'b0;
            end else begin
                e_dst      <= d_dst;
                e_tnew     <= Tnew;
                e_rs       <= d_rs;
                e_rt       <= d_rt;
                e_md_start <= d_md_start;
                e_md_div   <= d_md_div;
            end
            m_dst  <= e_dst;
            m_tnew <= dec_sat(e_tnew);
            m_rt   <= e_rt;
            w_dst  <= m_dst;
            w_tnew <= dec_sat(m_tnew);
        end
    end

    // Busy counter: loaded as a mult/div leaves E, then counts down to 0.
    // A load and a decrement never collide because the starting op stalls
    // any following HI/LO user while it sits in E.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 4'd0;
        end else if (e_md_start) begin
            busy <= e_md_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
        end else if (busy != 4'd0) begin
            busy <= busy - 4'd1;
        end
    end

    // Stall: a source whose producer in E or M is not ready in time, or a
    // HI/LO access while the mult/div unit is (or is about to be) busy.
    always_comb begin
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        stall_md = 1'b0;
        if (need_rs && d_rs != 5'd0) begin
            stall_rs = (e_dst == d_rs && e_tnew > Tuse_rs) ||
                       (m_dst == d_rs && m_tnew > Tuse_rs);
        end
        if (need_rt && d_rt != 5'd0) begin
            stall_rt = (e_dst == d_rt && e_tnew > Tuse_rt) ||
                       (m_dst == d_rt && m_tnew > Tuse_rt);
        end
        stall_md = d_md_use && (busy != 4'd0 || e_md_start);
        stall    = stall_rs || stall_rt || stall_md;
    end

    // Forwarding selects for the D, E and M consumers.
    always_comb begin
        fwd_d_rs = fwd_sel(d_rs, m_dst, m_tnew, w_dst, w_tnew);
        fwd_d_rt = fwd_sel(d_rt, m_dst, m_tnew, w_dst, w_tnew);
        fwd_e_rs = fwd_sel(e_rs, m_dst, m_tnew, w_dst, w_tnew);
        fwd_e_rt = fwd_sel(e_rt, m_dst, m_tnew, w_dst, w_tnew);
        fwd_m_rt = (m_rt != 5'd0) && (w_dst == m_rt) && (w_tnew == 3'd0);
        md_busy  = (busy != 4'd0);
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed expectations checked with
// immediate assertions. Inputs change on the falling edge and outputs are
// sampled 1 ns later, well away from the rising edge.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       need_rs, need_rt;
    logic [2:0] Tuse_rs, Tuse_rt, Tnew;
    logic [4:0] d_rs, d_rt, d_dst;
    logic       d_md_use, d_md_start, d_md_div;
    logic       stall;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
    logic       fwd_m_rt;
    logic       md_busy;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .need_rs    (need_rs),
        .need_rt    (need_rt),
        .Tuse_rs    (Tuse_rs),
        .Tuse_rt    (Tuse_rt),
        .Tnew       (Tnew),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_dst      (d_dst),
        .d_md_use   (d_md_use),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .stall      (stall),
        .fwd_d_rs   (fwd_d_rs),
        .fwd_d_rt   (fwd_d_rt),
        .fwd_e_rs   (fwd_e_rs),
        .fwd_e_rt   (fwd_e_rt),
        .fwd_m_rt   (fwd_m_rt),
        .md_busy    (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Put one instruction's decode tuple on the D inputs.
    task automatic set_d(input logic nrs, input logic nrt,
                         input logic [2:0] urs, input logic [2:0] urt,
                         input logic [2:0] tn,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dst,
                         input logic mu, input logic ms, input logic mdv);
        need_rs    = nrs;
        need_rt    = nrt;
        Tuse_rs    = urs;
        Tuse_rt    = urt;
        Tnew       = tn;
        d_rs       = rs;
        d_rt       = rt;
        d_dst      = dst;
        d_md_use   = mu;
        d_md_start = ms;
        d_md_div   = mdv;
    endtask

    task automatic set_nop();
        set_d(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance to the next falling edge (one rising edge passes).
    task automatic step();
        @(negedge clk);
    endtask

    // Compare every output against the expected set.
    task automatic chk(input string tag, input logic es,
                       input logic [1:0] edrs, input logic [1:0] edrt,
                       input logic [1:0] eers, input logic [1:0] eert,
                       input logic efm, input logic emb);
        #1;
        total++;
        assert (stall === es) else begin
            bad++;
            $error("FAIL %s.stall got=%0d exp=%0d", tag, stall, es);
        end
        total++;
        assert (fwd_d_rs === edrs) else begin
            bad++;
            $error("FAIL %s.fwd_d_rs got=%0d exp=%0d", tag, fwd_d_rs, edrs);
        end
        total++;
        assert (fwd_d_rt === edrt) else begin
            bad++;
            $error("FAIL %s.fwd_d_rt got=%0d exp=%0d", tag, fwd_d_rt, edrt);
        end
        total++;
        assert (fwd_e_rs === eers) else begin
            bad++;
            $error("FAIL %s.fwd_e_rs got=%0d exp=%0d", tag, fwd_e_rs, eers);
        end
        total++;
        assert (fwd_e_rt === eert) else begin
            bad++;
            $error("FAIL %s.fwd_e_rt got=%0d exp=%0d", tag, fwd_e_rt, eert);
        end
        total++;
        assert (fwd_m_rt === efm) else begin
            bad++;
            $error("FAIL %s.fwd_m_rt got=%0d exp=%0d", tag, fwd_m_rt, efm);
        end
        total++;
        assert (md_busy === emb) else begin
            bad++;
            $error("FAIL %s.md_busy got=%0d exp=%0d", tag, md_busy, emb);
        end
    endtask

    // Flush E, M and W with bubbles.
    task automatic drain();
        set_nop();
        repeat (4) step();
    endtask

    initial begin
        reset = 1'b1;
        set_nop();
        repeat (2) step();
        chk("reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        chk("idle", 0, 0, 0, 0, 0, 0, 0);

        // lw $1,0($2) ; addu $2,$1,$3
        set_d(1, 0, 3'd1, 3'd3, 3'd2, 5'd2, 5'd0, 5'd1, 0, 0, 0);
        chk("lw_use.lw", 0, 0, 0, 0, 0, 0, 0);
        step();
        set_d(1, 1, 3'd1, 3'd1, 3'd1, 5'd1, 5'd3, 5'd2, 0, 0, 0);
        chk("lw_use.stall", 1, 0, 0, 0, 0, 0, 0);
        step();
        chk("lw_use.go", 0, 0, 0, 0, 0, 0, 0);
        step();
        set_nop();
        chk("lw_use.fwd_e", 0, 0, 0, 2, 0, 0, 0);
        drain();

        // addu $1,$4,$5 ; beq $1,$1
        set_d(1, 1, 3'd1, 3'd1, 3'd1, 5'd4, 5'd5, 5'd1, 0, 0, 0);
        chk("alu_br.addu", 0, 0, 0, 0, 0, 0, 0);
        step();
        set_d(1, 1, 3'd0, 3'd0, 3'd0, 5'd1, 5'd1, 5'd0, 0, 0, 0);
        chk("alu_br.stall", 1, 0, 0, 0, 0, 0, 0);
        step();
        chk("alu_br.fwd_d", 0, 1, 1, 0, 0, 0, 0);
        drain();

        // lw $1,0($2) ; sw $1,0($2)
        set_d(1, 0, 3'd1, 3'd3, 3'd2, 5'd2, 5'd0, 5'd1, 0, 0, 0);
        chk("lw_sw.lw", 0, 0, 0, 0, 0, 0, 0);
        step();
        set_d(1, 1, 3'd1, 3'd2, 3'd0, 5'd2, 5'd1, 5'd0, 0, 0, 0);
        chk("lw_sw.nostall", 0, 0, 0, 0, 0, 0, 0);
        step();
        set_nop();
        chk("lw_sw.sw_in_e", 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("lw_sw.fwd_m", 0, 0, 0, 0, 0, 1, 0);
        drain();

        // addu $0,$4,$5 ; beq $0,$0 ; lw $0,0($0)
        set_d(1, 1, 3'd1, 3'd1, 3'd1, 5'd4, 5'd5, 5'd0, 0, 0, 0);
        chk("r0.addu", 0, 0, 0, 0, 0, 0, 0);
        step();
        set_d(1, 1, 3'd0, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        chk("r0.beq", 0, 0, 0, 0, 0, 0, 0);
        step();
        set_d(1, 0, 3'd1, 3'd3, 3'd2, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        chk("r0.lw", 0, 0, 0, 0, 0, 0, 0);
        step();
        set_nop();
        chk("r0.tail1", 0, 0, 0, 0, 0, 0, 0);
        step();
        chk("r0.tail2", 0, 0, 0, 0, 0, 0, 0);
        drain();

        // mult $4,$5 ; mfhi $6 : 1 + 5 stall cycles
        set_d(1, 1, 3'd1, 3'd1, 3'd0, 5'd4, 5'd5, 5'd0, 1, 1, 0);
        chk("mult.issue", 0, 0, 0, 0, 0, 0, 0);
        step();
        set_d(0, 0, 3'd0, 3'd0, 3'd1, 5'd0, 5'd0, 5'd6, 1, 0, 0);
        chk("mult.stall_e", 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mult.stall_busy", 1, 0, 0, 0, 0, 0, 1);
        end
        step();
        chk("mult.release", 0, 0, 0, 0, 0, 0, 0);
        drain();

        // div $4,$5 ; mfhi $6 : 1 + 10 stall cycles
        set_d(1, 1, 3'd1, 3'd1, 3'd0, 5'd4, 5'd5, 5'd0, 1, 1, 1);
        chk("div.issue", 0, 0, 0, 0, 0, 0, 0);
        step();
        set_d(0, 0, 3'd0, 3'd0, 3'd1, 5'd0, 5'd0, 5'd6, 1, 0, 0);
        chk("div.stall_e", 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("div.stall_busy", 1, 0, 0, 0, 0, 0, 1);
        end
        step();
        chk("div.release", 0, 0, 0, 0, 0, 0, 0);
        drain();

        // Reset mid-stall while a div busy count is running
        set_d(1, 1, 3'd1, 3'd1, 3'd0, 5'd4, 5'd5, 5'd0, 1, 1, 1);
        step();
        set_d(0, 0, 3'd0, 3'd0, 3'd1, 5'd0, 5'd0, 5'd6, 1, 0, 0);
        repeat (4) step();
        chk("rst_mid.before", 1, 0, 0, 0, 0, 0, 1);
        reset = 1'b1;
        chk("rst_mid.during", 0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        chk("rst_mid.after", 0, 0, 0, 0, 0, 0, 0);
        step();
        set_nop();
        chk("rst_mid.issued", 0, 0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
